ucsbece154b_bp_update_ctrl: RTL and testbench
=============================================

Name: ucsbece154b_bp_update_ctrl

Overview:
Sequences all training and recovery of the branch predictor (BTB + gshare PHT + GHR).
- Holds an in-order queue of predictions issued at fetch.
- Matches each against the resolved outcome from execute.
- Issues registered BTB/PHT write strobes and GHR reset.
- Raises a one-cycle flush/redirect on mispredict.
- Sits between fetch, the execute-stage branch unit and the predictor.

Parameters:
NUM_BTB_ENTRIES, 32, BTB entries; write index width = $clog2(NUM_BTB_ENTRIES)
NUM_GHR_BITS, 5, GHR/PHT address width
QUEUE_DEPTH, 4, in-flight prediction slots (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-low reset
pred_valid_i  in  1  fetch pushes a control-instruction prediction
pred_pc_i  in  32  PC of predicted instruction
pred_taken_i  in  1  predicted direction
pred_target_i  in  32  predicted target (don't-care if not taken)
pred_phtaddr_i  in  NUM_GHR_BITS  PHT index used at prediction
pred_ready_o  out  1  queue can accept a push
res_valid_i  in  1  execute resolves the oldest queued instruction
res_op_i  in  7  opcode of resolved instruction
res_taken_i  in  1  actual direction
res_target_i  in  32  actual target
flush_o  out  1  mispredict pulse
redirect_pc_o  out  32  fetch restart PC, valid with flush_o
BTB_we_o  out  1  BTB write strobe
BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  pc[idx+1:2]
BTBwritedata_o  out  32  target to store
op_o  out  7  opcode forwarded to predictor
PHTwe_o  out  1  PHT write strobe
PHTincrement_o  out  1  1=count up, 0=count down
PHTwriteaddress_o  out  NUM_GHR_BITS  PHT index to train
GHRreset_o  out  1  clear GHR
q_count_o  out  $clog2(QUEUE_DEPTH)+1  occupancy

Behaviour:
- Reset (reset_i=0, async):
  - Queue empty; q_count_o=0; FSM=INIT.
  - All strobes, flush_o, redirect_pc_o, BTB/PHT address and data outputs, op_o = 0.
- FSM INIT: one cycle after reset release, GHRreset_o=1, pred_ready_o=0, then RUN.
- RUN:
  - pred_ready_o = (q_count_o < QUEUE_DEPTH).
  - Push when pred_valid_i & pred_ready_o.
  - Pop the head when res_valid_i & queue non-empty.
  - Push and pop in the same cycle are both legal, including when full. At full, pred_ready_o stays 0 that cycle (registered-occupancy rule); count is unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- On pop, compare head against the resolution. Mispredict = (pred_taken != res_taken_i) | (res_taken_i & pred_target != res_target_i).
- Update outputs are registered, asserted exactly 1 cycle after the pop, for 1 cycle:
  - Conditional branch (op 1100011):
    - PHTwe_o=1; PHTwriteaddress_o=head phtaddr; PHTincrement_o=res_taken_i.
    - BTB_we_o=1 only if res_taken_i & (mispredict | !pred_taken).
  - jal/jalr: PHTwe_o=0; BTB_we_o=1 on mispredict.
  - Any other op: no writes.
  - op_o=res_op_i; BTBwritedata_o=res_target_i.
- Mispredict, same registered cycle as the update:
  - flush_o=1; GHRreset_o=1.
  - redirect_pc_o = res_taken_i ? res_target_i : head pc+4.
  - Queue cleared, including any same-cycle push.
  - FSM enters RECOVER: 1 cycle, pred_ready_o=0, pops ignored, then RUN.
- res_valid_i with empty queue: ignored, no strobes; in a push+res cycle on an empty queue, the resolution is still ignored.
- reset_i low mid-update: all strobes drop immediately.

Optional Feature:
BP_STATS_EN
- Defined: adds 32-bit saturating outputs stat_branches_o (count of resolved pops) and stat_mispredicts_o; both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- ucsbece154b_defines.vh already supplies instr_branch_op, instr_jal_op and instr_jalr_op; add FSM state encodings (INIT, RUN, RECOVER) and a queue-entry field layout (pc, taken, target, phtaddr).
- One natural sub-module: ucsbece154b_bp_pred_queue (parameterised FIFO with simultaneous push/pop, clear, and count).

Test Plan:
- Reset release -> GHRreset_o=1 for exactly 1 cycle at cycle 1; pred_ready_o=1 from cycle 2; all other outputs 0.
- Push branch pc=0x100 pred NT phtaddr=3; resolve branch NT -> next cycle PHTwe_o=1, addr=3, inc=0, BTB_we_o=0, flush_o=0.
- Push branch pc=0x104 pred NT; resolve taken target=0x200 -> PHTwe_o=1, inc=1, BTB_we_o=1, BTBwriteaddress_o=1, BTBwritedata_o=0x200, flush_o=1, redirect_pc_o=0x200, GHRreset_o=1, q_count_o=0, pred_ready_o=0 one cycle.
- jal pc=0x40 pred taken target=0x80; resolve taken target=0x80 -> no strobes; then with resolve target=0x90 -> BTB_we_o=1, data=0x90, flush_o=1, PHTwe_o=0.
- Fill 4 entries -> pred_ready_o=0; then push+pop in the same cycle -> q_count_o stays 4; wraparound order preserved over 10 entries.
- Branch pred taken target=0x300, pc=0x120, resolves NT -> flush_o=1, redirect_pc_o=0x124, PHTincrement_o=0, BTB_we_o=0.

Source files
------------

// File: rtl/ucsbece154b_bp_update_ctrl_pkg.sv
// Shared types and constants for the branch-predictor update controller.
// Holds the opcode constants, FSM state encoding and the layout of a queued prediction.
package ucsbece154b_bp_update_ctrl_pkg;

    // RISC-V major opcodes for control-flow instructions.
    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    typedef enum logic [1:0] {
        StInit    = 2'd0,
        StRun     = 2'd1,
        StRecover = 2'd2
    } bp_state_e;

    // Fixed-width part of a queue entry; the PHT index is appended below it
    // because its width depends on NUM_GHR_BITS.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_info_t;

    localparam int unsigned PredInfoWidth = $bits(pred_info_t);

    function automatic logic is_jump(input logic [6:0] op);
        return (op == instr_jal_op) || (op == instr_jalr_op);
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_pred_queue.sv
// In-order prediction FIFO with simultaneous push/pop, synchronous clear and occupancy count.
// The caller guarantees pops only when non-empty and pushes only when not full
// (or when a pop in the same cycle frees the slot).
module ucsbece154b_bp_pred_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Pointer and occupancy bookkeeping; clear wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ucsbece154b_bp_update_ctrl.sv
// Branch-predictor update controller: queues fetch-time predictions, matches them
// in order against execute-stage resolutions, and issues registered BTB/PHT training
// strobes, GHR clears and a one-cycle flush/redirect on mispredict.
// Optional feature macro: BP_STATS_EN adds saturating resolve/mispredict counters.
module ucsbece154b_bp_update_ctrl
    import ucsbece154b_bp_update_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 5,
    parameter int unsigned QUEUE_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               pred_valid_i,
    input  logic [31:0]                        pred_pc_i,
    input  logic                               pred_taken_i,
    input  logic [31:0]                        pred_target_i,
    input  logic [NUM_GHR_BITS-1:0]            pred_phtaddr_i,
    output logic                               pred_ready_o,
    input  logic                               res_valid_i,
    input  logic [6:0]                         res_op_i,
    input  logic                               res_taken_i,
    input  logic [31:0]                        res_target_i,
    output logic                               flush_o,
    output logic [31:0]                        redirect_pc_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic [6:0]                         op_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
    output logic [$clog2(QUEUE_DEPTH):0]       q_count_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0]                        stat_branches_o,
    output logic [31:0]                        stat_mispredicts_o
`endif
);

    localparam int unsigned BtbIdxW = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned CountW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned EntryW  = PredInfoWidth + NUM_GHR_BITS;

    bp_state_e state_q, state_d;

    pred_info_t              push_info, head_info;
    logic [NUM_GHR_BITS-1:0] head_phtaddr;
    logic [EntryW-1:0]       push_entry, head_entry;
    logic [CountW-1:0]       q_count;
    logic q_push, q_pop, q_clear, q_full, q_empty, in_run;
    logic mispredict, mispredict_pop;

    logic                    btb_we_q, btb_we_d;
    logic                    pht_we_q, pht_we_d;
    logic                    pht_inc_q, pht_inc_d;
    logic                    flush_q, flush_d;
    logic                    ghr_reset_q, ghr_reset_d;
    logic [BtbIdxW-1:0]      btb_addr_q, btb_addr_d;
    logic [31:0]             btb_data_q, btb_data_d;
    logic [31:0]             redirect_q, redirect_d;
    logic [6:0]              op_q, op_d;
    logic [NUM_GHR_BITS-1:0] pht_addr_q, pht_addr_d;

    // Pack the incoming prediction and unpack the queue head.
    always_comb begin
        push_info.pc     = pred_pc_i;
        push_info.taken  = pred_taken_i;
        push_info.target = pred_target_i;
        push_entry       = {push_info, pred_phtaddr_i};
        {head_info, head_phtaddr} = head_entry;
    end

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == CountW'(QUEUE_DEPTH));
    assign in_run  = (state_q == StRun);
    assign q_pop   = in_run & res_valid_i & ~q_empty;
    // A pop frees the head slot, so a full queue may still take a same-cycle push.
    assign q_push  = in_run & pred_valid_i & (~q_full | q_pop);

    assign mispredict = (head_info.taken != res_taken_i) |
                        (res_taken_i & (head_info.target != res_target_i));
    assign mispredict_pop = q_pop & mispredict;
    assign q_clear        = mispredict_pop;

    ucsbece154b_bp_pred_queue #(
        .WIDTH (EntryW),
        .DEPTH (QUEUE_DEPTH)
    ) u_pred_queue (
        .clk         (clk),
        .reset_i     (reset_i),
        .clear_i     (q_clear),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .head_o      (head_entry),
        .count_o     (q_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) state_q <= StInit;
        else          state_q <= state_d;
    end

    // FSM next state; INIT leaves once its GHR clear has been issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:    if (ghr_reset_q) state_d = StRun;
            StRun:     if (mispredict_pop) state_d = StRecover;
            StRecover: state_d = StRun;
            default:   state_d = StInit;
        endcase
    end

    // FSM outputs: fetch may push only while running with room.
    always_comb begin
        pred_ready_o = (state_q == StRun) & ~q_full;
    end

    // Next values of the registered training/recovery outputs; data fields hold between pops.
    always_comb begin
        btb_we_d    = 1'b0;
        pht_we_d    = 1'b0;
        flush_d     = 1'b0;
        ghr_reset_d = (state_q == StInit) & ~ghr_reset_q;
        pht_inc_d   = pht_inc_q;
        btb_addr_d  = btb_addr_q;
        btb_data_d  = btb_data_q;
        redirect_d  = redirect_q;
        op_d        = op_q;
        pht_addr_d  = pht_addr_q;
        if (q_pop) begin
            op_d       = res_op_i;
            btb_data_d = res_target_i;
            btb_addr_d = head_info.pc[BtbIdxW+1:2];
            pht_addr_d = head_phtaddr;
            pht_inc_d  = res_taken_i;
            if (res_op_i == instr_branch_op) begin
                pht_we_d = 1'b1;
                btb_we_d = res_taken_i & (mispredict | ~head_info.taken);
            end else if (is_jump(res_op_i)) begin
                btb_we_d = mispredict;
            end
            if (mispredict) begin
                flush_d     = 1'b1;
                ghr_reset_d = 1'b1;
                redirect_d  = res_taken_i ? res_target_i : head_info.pc + 32'd4;
            end
        end
    end

    // Registered outputs; async reset drops every strobe immediately.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            btb_we_q    <= 1'b0;
            pht_we_q    <= 1'b0;
            pht_inc_q   <= 1'b0;
            flush_q     <= 1'b0;
            ghr_reset_q <= 1'b0;
            btb_addr_q  <= '0;
            btb_data_q  <= '0;
            redirect_q  <= '0;
            op_q        <= '0;
            pht_addr_q  <= '0;
        end else begin
            btb_we_q    <= btb_we_d;
            pht_we_q    <= pht_we_d;
            pht_inc_q   <= pht_inc_d;
            flush_q     <= flush_d;
            ghr_reset_q <= ghr_reset_d;
            btb_addr_q  <= btb_addr_d;
            btb_data_q  <= btb_data_d;
            redirect_q  <= redirect_d;
            op_q        <= op_d;
            pht_addr_q  <= pht_addr_d;
        end
    end

    assign BTB_we_o          = btb_we_q;
    assign BTBwriteaddress_o = btb_addr_q;
    assign BTBwritedata_o    = btb_data_q;
    assign op_o              = op_q;
    assign PHTwe_o           = pht_we_q;
    assign PHTincrement_o    = pht_inc_q;
    assign PHTwriteaddress_o = pht_addr_q;
    assign GHRreset_o        = ghr_reset_q;
    assign flush_o           = flush_q;
    assign redirect_pc_o     = redirect_q;
    assign q_count_o         = q_count;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Saturating counters of resolved pops and of mispredicts among them.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (q_pop && (stat_br_q != '1))          stat_br_q <= stat_br_q + 32'd1;
            if (mispredict_pop && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o    = stat_br_q;
    assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_bp_update_ctrl.sv
// Self-checking bench for ucsbece154b_bp_update_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_ucsbece154b_bp_update_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        pred_valid_i, pred_taken_i, res_valid_i, res_taken_i;
    logic [31:0] pred_pc_i, pred_target_i, res_target_i;
    logic [4:0]  pred_phtaddr_i;
    logic [6:0]  res_op_i;
    logic        pred_ready_o, flush_o, BTB_we_o, PHTwe_o, PHTincrement_o, GHRreset_o;
    logic [31:0] redirect_pc_o, BTBwritedata_o;
    logic [4:0]  BTBwriteaddress_o, PHTwriteaddress_o;
    logic [6:0]  op_o;
    logic [2:0]  q_count_o;

    always #5 clk = ~clk;

    ucsbece154b_bp_update_ctrl #(
        .NUM_BTB_ENTRIES (32),
        .NUM_GHR_BITS    (5),
        .QUEUE_DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .pred_valid_i      (pred_valid_i),
        .pred_pc_i         (pred_pc_i),
        .pred_taken_i      (pred_taken_i),
        .pred_target_i     (pred_target_i),
        .pred_phtaddr_i    (pred_phtaddr_i),
        .pred_ready_o      (pred_ready_o),
        .res_valid_i       (res_valid_i),
        .res_op_i          (res_op_i),
        .res_taken_i       (res_taken_i),
        .res_target_i      (res_target_i),
        .flush_o           (flush_o),
        .redirect_pc_o     (redirect_pc_o),
        .BTB_we_o          (BTB_we_o),
        .BTBwriteaddress_o (BTBwriteaddress_o),
        .BTBwritedata_o    (BTBwritedata_o),
        .op_o              (op_o),
        .PHTwe_o           (PHTwe_o),
        .PHTincrement_o    (PHTincrement_o),
        .PHTwriteaddress_o (PHTwriteaddress_o),
        .GHRreset_o        (GHRreset_o),
        .q_count_o         (q_count_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [4:0]  pht;
    } ent_t;

    // Model state: outstanding predictions, and a phase counter
    // (0 = just out of reset, 1 = GHR-clear cycle, 2 = running, 3 = recovering).
    ent_t        mq[$];
    int          mode;
    logic        e_btbwe, e_phtwe, e_inc, e_flush, e_ghr;
    logic [4:0]  e_baddr, e_phtaddr;
    logic [31:0] e_bdata, e_redirect;
    logic [6:0]  e_op;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        mode       = 0;
        e_btbwe    = 0;
        e_phtwe    = 0;
        e_inc      = 0;
        e_flush    = 0;
        e_ghr      = 0;
        e_baddr    = 0;
        e_phtaddr  = 0;
        e_bdata    = 0;
        e_redirect = 0;
        e_op       = 0;
    endtask

    task automatic check_outputs();
        check("pred_ready", pred_ready_o, (mode == 2 && mq.size() < DEPTH));
        check("q_count", q_count_o, mq.size());
        check("flush", flush_o, e_flush);
        check("ghr_reset", GHRreset_o, e_ghr);
        check("btb_we", BTB_we_o, e_btbwe);
        check("pht_we", PHTwe_o, e_phtwe);
        check("pht_inc", PHTincrement_o, e_inc);
        check("pht_addr", PHTwriteaddress_o, e_phtaddr);
        check("btb_addr", BTBwriteaddress_o, e_baddr);
        check("btb_data", BTBwritedata_o, e_bdata);
        check("op", op_o, e_op);
        check("redirect", redirect_pc_o, e_redirect);
    endtask

    // Drive one cycle of inputs, predict the registered outcome, then compare after the edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic ptk,
                        input logic [31:0] ptgt, input logic [4:0] ppht, input logic rv,
                        input logic [6:0] rop, input logic rtk, input logic [31:0] rtgt);
        bit   do_pop, do_push, mp;
        ent_t h, n;
        int   nmode;
        pred_valid_i = pv;  pred_pc_i = ppc;  pred_taken_i = ptk;
        pred_target_i = ptgt;  pred_phtaddr_i = ppht;
        res_valid_i = rv;  res_op_i = rop;  res_taken_i = rtk;  res_target_i = rtgt;
        e_btbwe = 0;  e_phtwe = 0;  e_flush = 0;  e_ghr = 0;
        do_pop = 0;  do_push = 0;  mp = 0;
        nmode = mode;
        case (mode)
            0: begin e_ghr = 1; nmode = 1; end
            1: nmode = 2;
            3: nmode = 2;
            default: begin
                do_pop  = rv && mq.size() > 0;
                do_push = pv && (mq.size() < DEPTH || do_pop);
                if (do_pop) begin
                    h = mq[0];
                    mp = (h.taken != rtk) || (rtk && h.target != rtgt);
                    e_op = rop;  e_bdata = rtgt;  e_baddr = h.pc[6:2];
                    e_phtaddr = h.pht;  e_inc = rtk;
                    if (rop == OP_BR) begin
                        e_phtwe = 1;
                        e_btbwe = rtk && (mp || !h.taken);
                    end else if (rop == OP_JAL || rop == OP_JALR) begin
                        e_btbwe = mp;
                    end
                    if (mp) begin
                        e_flush = 1;  e_ghr = 1;
                        e_redirect = rtk ? rtgt : h.pc + 32'd4;
                    end
                end
                if (mp) begin
                    mq.delete();
                    nmode = 3;
                end else begin
                    if (do_pop) void'(mq.pop_front());
                    if (do_push) begin
                        n.pc = ppc;  n.taken = ptk;  n.target = ptgt;  n.pht = ppht;
                        mq.push_back(n);
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
        mode = nmode;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic [4:0] pht);
        step(1, pc, tk, tgt, pht, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [6:0] op, input logic tk, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 1, op, tk, tgt);
    endtask

    // Return to running with an empty queue by resolving everything correctly.
    task automatic settle();
        for (int k = 0; k < 12; k++) begin
            if (mode != 2) idle();
            else if (mq.size() > 0) resolve(OP_BR, mq[0].taken, mq[0].target);
        end
    endtask

    initial begin
        reset_i = 0;
        pred_valid_i = 0;  pred_pc_i = 0;  pred_taken_i = 0;  pred_target_i = 0;
        pred_phtaddr_i = 0;  res_valid_i = 0;  res_op_i = 0;  res_taken_i = 0;
        res_target_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_i = 1;

        // Init: GHR clear for one cycle, then ready.
        idle();
        check("init_ghr", GHRreset_o, 1);
        check("init_ready_low", pred_ready_o, 0);
        idle();
        check("init_ready_high", pred_ready_o, 1);

        // Correctly predicted not-taken branch.
        push(32'h100, 0, 0, 5'd3);
        resolve(OP_BR, 0, 0);
        check("d1_pht_we", PHTwe_o, 1);
        check("d1_pht_addr", PHTwriteaddress_o, 3);
        check("d1_flush", flush_o, 0);

        // Predicted not-taken, actually taken.
        push(32'h104, 0, 0, 5'd7);
        resolve(OP_BR, 1, 32'h200);
        check("d2_btb_addr", BTBwriteaddress_o, 1);
        check("d2_redirect", redirect_pc_o, 32'h200);
        check("d2_btb_we", BTB_we_o, 1);
        check("d2_ready", pred_ready_o, 0);
        idle();

        // jal: correct target, then wrong target.
        push(32'h40, 1, 32'h80, 5'd0);
        resolve(OP_JAL, 1, 32'h80);
        check("d3_btb_we_ok", BTB_we_o, 0);
        push(32'h40, 1, 32'h80, 5'd0);
        resolve(OP_JAL, 1, 32'h90);
        check("d3_btb_data", BTBwritedata_o, 32'h90);
        check("d3_flush", flush_o, 1);
        idle();

        // Fill, then push+pop at full, then wrap through ten entries.
        for (int i = 0; i < 4; i++) push(32'h200 + 4 * i, 0, 0, 5'(i));
        check("d4_full_ready", pred_ready_o, 0);
        for (int i = 4; i < 10; i++) begin
            step(1, 32'h200 + 4 * i, 0, 0, 5'(i), 1, OP_BR, 0, 0);
            check("d4_count_full", q_count_o, 4);
        end
        for (int i = 0; i < 4; i++) resolve(OP_BR, 0, 0);
        check("d4_last_pht", PHTwriteaddress_o, 9);

        // Predicted taken, actually not taken.
        push(32'h120, 1, 32'h300, 5'd2);
        resolve(OP_BR, 0, 0);
        check("d5_redirect", redirect_pc_o, 32'h124);
        check("d5_btb_we", BTB_we_o, 0);
        idle();

        // Resolution against an empty queue is ignored even with a same-cycle push.
        step(1, 32'h500, 0, 0, 5'd1, 1, OP_BR, 0, 0);
        check("d6_no_pht_we", PHTwe_o, 0);
        resolve(OP_BR, 0, 0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            logic        pv, rv, ptk, rtk;
            logic [31:0] ppc, ptgt, rtgt;
            logic [4:0]  ppht;
            logic [6:0]  rop;
            int          r;
            pv   = ($urandom_range(0, 99) < 60);
            ppc  = $urandom & 32'hFFFF_FFFC;
            ptk  = 1'($urandom_range(0, 1));
            ptgt = $urandom & 32'hFFFF_FFFC;
            ppht = 5'($urandom_range(0, 31));
            rv   = ($urandom_range(0, 99) < 45);
            r    = $urandom_range(0, 3);
            rop  = (r == 0) ? OP_BR : (r == 1) ? OP_JAL : (r == 2) ? OP_JALR : OP_ALU;
            if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
                rtk  = mq[0].taken;
                rtgt = rtk ? mq[0].target : ($urandom & 32'hFFFF_FFFC);
            end else begin
                rtk  = 1'($urandom_range(0, 1));
                rtgt = $urandom & 32'hFFFF_FFFC;
            end
            step(pv, ppc, ptk, ptgt, ppht, rv, rop, rtk, rtgt);
        end

        // Reset asserted while a mispredict update is on the outputs.
        settle();
        push(32'h120, 1, 32'h300, 5'd2);
        resolve(OP_BR, 0, 0);
        check("rst_pre_flush", flush_o, 1);
        reset_i = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset_i = 1;
        idle();
        idle();
        check("post_rst_ready", pred_ready_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
